senior_bit_iterator: RTL and testbench

Sequential drain of a loaded word into its set bits, one per beat, senior (MSB) first. Each beat carries the one-hot of the current senior set bit and, optionally, its binary index. The drain uses the existing combinational senior-bit screen internally. It sits between a request/flag-vector producer (interrupt pending mask, allocation bitmap) and a consumer that services one bit at a time under valid/ready backpressure.

---
 rtl/screening_pkg.sv | 23 ++
 rtl/screening_by_senior.sv | 27 ++
 rtl/senior_bit_iterator.sv | 110 +++++++++++
 tb/tb_senior_bit_iterator.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/screening_pkg.sv
// Shared types and helpers for the senior-bit screening blocks.
package screening_pkg;

    typedef enum logic {IDLE, DRAIN} iter_state_t;

    localparam int unsigned MAX_WORD_WIDTH = 64;
    localparam int unsigned MAX_INDEX_WIDTH = $clog2(MAX_WORD_WIDTH);

    // Binary position of a one-hot word; returns 0 for an all-zero word.
    function automatic logic [MAX_INDEX_WIDTH-1:0] onehot_to_index(
        input logic [MAX_WORD_WIDTH-1:0] onehot
    );
        logic [MAX_INDEX_WIDTH-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_WORD_WIDTH; i++) begin
            if (onehot[i]) begin
                idx = MAX_INDEX_WIDTH'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/screening_by_senior.sv
// Combinational senior-bit screen: keeps only the most significant set bit of x_i
// unless a more senior stage already claimed it (c_i); c_o flags any claim.
module screening_by_senior #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  c_i,
    input  logic [WORD_WIDTH-1:0] x_i,
    output logic [WORD_WIDTH-1:0] y_o,
    output logic                  c_o
);

    logic found;

    always_comb begin
        y_o   = '0;
        found = c_i;
        for (int unsigned j = 0; j < WORD_WIDTH; j++) begin
            if (x_i[WORD_WIDTH-1-j] && !found) begin
                y_o[WORD_WIDTH-1-j] = 1'b1;
                found               = 1'b1;
            end
        end
    end

    assign c_o = c_i | (|x_i);

endmodule

// File: rtl/senior_bit_iterator.sv
// Drains a loaded word into one beat per set bit, MSB first, under valid/ready.
// Optional binary index output enabled by defining SENIOR_ITER_INDEX_EN.
module senior_bit_iterator
    import screening_pkg::*;
#(
    parameter int WORD_WIDTH = 8
`ifdef SENIOR_ITER_INDEX_EN
    ,
    localparam int INDEX_WIDTH = $clog2(WORD_WIDTH)
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_valid_i,
    output logic                   load_ready_o,
    input  logic [WORD_WIDTH-1:0]  data_i,
    input  logic                   abort_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WORD_WIDTH-1:0]  onehot_o,
`ifdef SENIOR_ITER_INDEX_EN
    output logic [INDEX_WIDTH-1:0] index_o,
`endif
    output logic                   last_o
);

    iter_state_t           state_q, state_d;
    logic [WORD_WIDTH-1:0] remaining_q, remaining_d;
    logic [WORD_WIDTH-1:0] senior;
    logic                  is_last;
    logic                  draining;

    screening_by_senior #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_screen (
        .c_i(1'b0),
        .x_i(remaining_q),
        .y_o(senior),
        .c_o()
    );

    assign draining = (state_q == DRAIN);
    assign is_last  = ((remaining_q & ~senior) == '0);

    always_comb begin
        out_valid_o  = 1'b0;
        load_ready_o = 1'b0;
        onehot_o     = '0;
        last_o       = 1'b0;
        if (!rst_i) begin
            out_valid_o  = draining;
            load_ready_o = !draining || (out_ready_i && is_last);
            onehot_o     = senior;
            last_o       = draining && is_last;
        end
    end

`ifdef SENIOR_ITER_INDEX_EN
    always_comb begin
        index_o = '0;
        if (!rst_i) begin
            index_o = INDEX_WIDTH'(onehot_to_index(MAX_WORD_WIDTH'(senior)));
        end
    end
`endif

    // Abort wins over both the beat handshake and a same-cycle back-to-back load.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (load_valid_i) begin
                    remaining_d = data_i;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    remaining_d = '0;
                    state_d     = IDLE;
                end else if (out_ready_i) begin
                    remaining_d = remaining_q & ~senior;
                    if (is_last) begin
                        if (load_valid_i) begin
                            remaining_d = data_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                remaining_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_senior_bit_iterator.sv
// Directed test-plan scenarios followed by random traffic, checked against a
// queue-of-beats reference model of senior_bit_iterator (WORD_WIDTH=8).
module tb_senior_bit_iterator;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       load_valid_i;
    logic       load_ready_o;
    logic [7:0] data_i;
    logic       abort_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] onehot_o;
`ifdef SENIOR_ITER_INDEX_EN
    logic [2:0] index_o;
`endif
    logic       last_o;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Pending beats of the word in flight: bit positions, -1 for an empty-word beat.
    int q[$];

    always #5 clk = ~clk;

    senior_bit_iterator #(
        .WORD_WIDTH(8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .load_valid_i(load_valid_i),
        .load_ready_o(load_ready_o),
        .data_i      (data_i),
        .abort_i     (abort_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .onehot_o    (onehot_o),
`ifdef SENIOR_ITER_INDEX_EN
        .index_o     (index_o),
`endif
        .last_o      (last_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void load_model(input logic [7:0] d);
        q.delete();
        for (int i = 7; i >= 0; i--) begin
            if (d[i]) q.push_back(i);
        end
        if (q.size() == 0) q.push_back(-1);
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic lv, input logic [7:0] d, input logic ordy,
                        input logic ab, input logic rs);
        logic        busy;
        logic        exp_lr;
        logic [31:0] exp_oh;
        logic [31:0] exp_idx;
        load_valid_i = lv;
        data_i       = d;
        out_ready_i  = ordy;
        abort_i      = ab;
        rst_i        = rs;
        #4;
        busy    = (q.size() > 0);
        exp_lr  = !rs && (!busy || (ordy && q.size() == 1));
        exp_oh  = (!rs && busy && q[0] >= 0) ? (32'd1 << q[0]) : 32'd0;
        exp_idx = (!rs && busy && q[0] >= 0) ? 32'(q[0]) : 32'd0;
        chk("out_valid", 32'(out_valid_o), 32'(!rs && busy));
        chk("load_ready", 32'(load_ready_o), 32'(exp_lr));
        chk("onehot", 32'(onehot_o), exp_oh);
        if (rs || busy) chk("last", 32'(last_o), 32'(!rs && q.size() == 1));
`ifdef SENIOR_ITER_INDEX_EN
        chk("index", 32'(index_o), exp_idx);
`endif
        @(posedge clk);
        if (rs) begin
            q.delete();
        end else if (busy && ab) begin
            q.delete();
        end else begin
            if (busy && ordy) void'(q.pop_front());
            if (lv && exp_lr) load_model(d);
        end
        #1;
    endtask

    initial begin
        logic [7:0] rd;
        int unsigned sel;
        rst_i        = 1'b1;
        load_valid_i = 1'b0;
        data_i       = '0;
        abort_i      = 1'b0;
        out_ready_i  = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // 0xA4 drains as 0x80, 0x20, 0x04 back to back
        step(1'b1, 8'hA4, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // zero word gives a single terminator beat
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // backpressure holds the beat
        step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // back-to-back load on the last beat
        step(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h90, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // abort mid-word, with a competing load
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // abort in idle does not block a load
        step(1'b1, 8'h12, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // reset mid-drain discards the word
        step(1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 9);
            rd  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            step(1'($urandom_range(0, 1)), rd, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
